// File: rtl/pwm_level_decoder.sv
// pwm_level_decoder: measures an asynchronous PWM line over fixed windows of
// 2^WIN_BITS clocks and reports its high-cycle count, its rising-edge count and
// a filtered five-step brightness level (0%, 12.5%, 25%, 50%, 100%).
module pwm_level_decoder #(
    parameter int WIN_BITS = 16,
    parameter int STABLE   = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                pwm_in,
    input  logic                enable,
    output logic [WIN_BITS:0]   duty,
    output logic                duty_valid,
    output logic [7:0]          edges,
    output logic [2:0]          level,
    output logic                level_valid,
    output logic                level_change
);
    localparam int DW = WIN_BITS + 1;
    localparam int W  = 1 << WIN_BITS;

    // Quantisation thresholds are exact fractions of W (W is a multiple of 16).
    localparam logic [DW-1:0] T1 = DW'(W / 16);
    localparam logic [DW-1:0] T2 = DW'(3 * W / 16);
    localparam logic [DW-1:0] T3 = DW'(3 * W / 8);
    localparam logic [DW-1:0] T4 = DW'(3 * W / 4);
    localparam logic [2:0]    STABLE_C = 3'(STABLE);

    logic                s1, s, s_d;
    logic [WIN_BITS-1:0] win_cnt;
    logic [DW-1:0]       hi_cnt;
    logic [7:0]          edge_cnt;
    logic [2:0]          cand, stable_cnt;

    logic                rise, close;
    logic [DW-1:0]       total;
    logic [7:0]          edge_total;
    logic [2:0]          q, stable_nx;
    logic                publish;

    // Closing-cycle arithmetic: the last sample and edge of a window are folded
    // in here so the counters can restart at 0 without losing a cycle.
    always_comb begin
        rise       = s & ~s_d;
        close      = enable & (&win_cnt);
        total      = hi_cnt + DW'(s);
        edge_total = (edge_cnt == 8'hFF) ? 8'hFF : edge_cnt + 8'(rise);

        q = 3'd4;
        if (total < T1)      q = 3'd0;
        else if (total < T2) q = 3'd1;
        else if (total < T3) q = 3'd2;
        else if (total < T4) q = 3'd3;

        if (q == cand && stable_cnt != 3'd0)
            stable_nx = (stable_cnt >= STABLE_C) ? STABLE_C : stable_cnt + 3'd1;
        else
            stable_nx = 3'd1;

        publish = (stable_nx == STABLE_C) && (level != q || !level_valid);
    end

    // Two-flop synchroniser plus one delay flop for rising-edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1  <= 1'b0;
            s   <= 1'b0;
            s_d <= 1'b0;
        end else begin
            s1  <= pwm_in;
            s   <= s1;
            s_d <= s;
        end
    end

    // Window counters; cleared while disabled so a re-enable starts a full window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_cnt  <= '0;
            hi_cnt   <= '0;
            edge_cnt <= '0;
        end else if (!enable) begin
            win_cnt  <= '0;
            hi_cnt   <= '0;
            edge_cnt <= '0;
        end else if (close) begin
            win_cnt  <= '0;
            hi_cnt   <= '0;
            edge_cnt <= '0;
        end else begin
            win_cnt  <= win_cnt + 1'b1;
            hi_cnt   <= total;
            edge_cnt <= edge_total;
        end
    end

    // Window results, stability filter and published level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            duty         <= '0;
            duty_valid   <= 1'b0;
            edges        <= '0;
            level        <= '0;
            level_valid  <= 1'b0;
            level_change <= 1'b0;
            cand         <= '0;
            stable_cnt   <= '0;
        end else begin
            duty_valid   <= 1'b0;
            level_change <= 1'b0;
            if (!enable) begin
                stable_cnt <= '0;
            end else if (close) begin
                duty       <= total;
                edges      <= edge_total;
                duty_valid <= 1'b1;
                cand       <= q;
                stable_cnt <= stable_nx;
                if (publish) begin
                    level        <= q;
                    level_valid  <= 1'b1;
                    level_change <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_pwm_level_decoder.sv
// Bench for pwm_level_decoder: two instances (STABLE=2 and STABLE=1) share the
// inputs; a window-level reference model predicts every output.
module tb_pwm_level_decoder;
    localparam int WB = 4;
    localparam int W  = 1 << WB;

    logic clk = 1'b0, rst_n = 1'b0, pwm_in = 1'b0, enable = 1'b0;
    logic [WB:0] duty2, duty1;
    logic [7:0]  edg2, edg1;
    logic [2:0]  lvl2, lvl1;
    logic        dv2, dv1, lv2, lv1, lc2, lc1;

    int errors = 0;
    int checks = 0;
    int ph = 0;

    pwm_level_decoder #(.WIN_BITS(WB), .STABLE(2)) d2 (
        .clk(clk), .rst_n(rst_n), .pwm_in(pwm_in), .enable(enable),
        .duty(duty2), .duty_valid(dv2), .edges(edg2), .level(lvl2),
        .level_valid(lv2), .level_change(lc2));

    pwm_level_decoder #(.WIN_BITS(WB), .STABLE(1)) d1 (
        .clk(clk), .rst_n(rst_n), .pwm_in(pwm_in), .enable(enable),
        .duty(duty1), .duty_valid(dv1), .edges(edg1), .level(lvl1),
        .level_valid(lv1), .level_change(lc1));

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // h: raw pwm_in seen at each clock; the value counted at a clock is the one
    // seen two clocks earlier. ws/wr: samples and rising edges of the open
    // window. lq: levels of completed windows since measurement (re)started.
    bit h[$];
    bit ws[$];
    bit wr[$];
    int lq[$];
    int m_duty, m_edges, m_lvl[2];
    bit m_dv, m_lv[2], m_lc[2];
    int c_sum, e_sum, q_lv;
    bit run_ok;

    function automatic int quant(input int c);
        if (c * 16 < W)     return 0;
        if (c * 16 < 3 * W) return 1;
        if (c * 8 < 3 * W)  return 2;
        if (c * 4 < 3 * W)  return 3;
        return 4;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h = '{0, 0, 0};
            ws.delete(); wr.delete(); lq.delete();
            m_duty <= 0; m_edges <= 0; m_dv <= 0;
            m_lvl <= '{0, 0}; m_lv <= '{0, 0}; m_lc <= '{0, 0};
        end else begin
            m_dv <= 0;
            m_lc <= '{0, 0};
            if (enable) begin
                ws.push_back(h[h.size()-2]);
                wr.push_back(h[h.size()-2] & ~h[h.size()-3]);
                if (ws.size() == W) begin
                    c_sum = 0; e_sum = 0;
                    for (int i = 0; i < W; i++) begin
                        c_sum += int'(ws[i]);
                        e_sum += int'(wr[i]);
                    end
                    m_duty  <= c_sum;
                    m_edges <= (e_sum > 255) ? 255 : e_sum;
                    m_dv    <= 1;
                    q_lv = quant(c_sum);
                    lq.push_back(q_lv);
                    if (lq.size() > 8) void'(lq.pop_front());
                    for (int k = 0; k < 2; k++) begin
                        // k=0 models STABLE=2, k=1 models STABLE=1
                        run_ok = (lq.size() >= 2 - k);
                        if (k == 0 && run_ok) run_ok = (lq[lq.size()-2] == q_lv);
                        if (run_ok && (m_lvl[k] != q_lv || !m_lv[k])) begin
                            m_lvl[k] <= q_lv;
                            m_lv[k]  <= 1;
                            m_lc[k]  <= 1;
                        end
                    end
                    ws.delete(); wr.delete();
                end
            end else begin
                ws.delete(); wr.delete(); lq.delete();
            end
            h.push_back(pwm_in);
            if (h.size() > 4) void'(h.pop_front());
        end
    end

    // One clock of stimulus: inputs change at negedge, outputs read at the next negedge.
    task automatic cyc(input bit p, input bit en);
        pwm_in = p;
        enable = en;
        @(posedge clk);
        @(negedge clk);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 0; enable = 0; pwm_in = 0;
        repeat (3) @(negedge clk);
        checks++; if ({duty2, edg2, dv2} !== '0) begin errors++; $display("FAIL rst_meas got=%0d/%0d/%0d exp=0", duty2, edg2, dv2); end
        checks++; if ({lvl2, lv2, lc2, lvl1, lv1, lc1} !== '0) begin errors++; $display("FAIL rst_level got=%0d/%0d/%0d exp=0", lvl2, lv2, lc2); end
        rst_n = 1;
    endtask

    task automatic test_const_high();
        int nwin = 0, nlc = 0;
        for (int i = 0; i < 4; i++) cyc(1, 0);
        for (int i = 0; i < 3 * W + 2; i++) begin
            cyc(1, 1);
            checks++; if (dv2 !== m_dv) begin errors++; $display("FAIL hi_dv cyc=%0d got=%0b exp=%0b", i, dv2, m_dv); end
            if (lc2) nlc++;
            if (dv2) begin
                nwin++;
                checks++; if (duty2 !== 5'd16 || edg2 !== 8'd0) begin errors++; $display("FAIL hi_duty win=%0d got=%0d/%0d exp=16/0", nwin, duty2, edg2); end
                checks++; if (lc2 !== (nwin == 2)) begin errors++; $display("FAIL hi_lc win=%0d got=%0b exp=%0b", nwin, lc2, nwin == 2); end
            end
        end
        checks++; if (lvl2 !== 3'd4 || lv2 !== 1'b1 || nlc != 1) begin errors++; $display("FAIL hi_level got=%0d/%0b/%0d exp=4/1/1", lvl2, lv2, nlc); end
    endtask

    task automatic test_async_reset();
        int n = 0;
        for (int i = 0; i < 7; i++) cyc(i[0], 1);
        #2 rst_n = 0;
        #1;
        checks++; if ({duty2, edg2, dv2, lvl2, lv2, lc2, lvl1, lv1} !== '0) begin errors++; $display("FAIL arst_clear got duty=%0d lvl=%0d lv=%0b exp=0", duty2, lvl2, lv2); end
        @(negedge clk);
        rst_n = 1;
        pwm_in = 1; enable = 1;
        while (n < 40) begin
            @(posedge clk); @(negedge clk); n++;
            pwm_in = ~pwm_in;
            if (dv2) break;
        end
        checks++; if (n != W) begin errors++; $display("FAIL arst_latency got=%0d exp=%0d", n, W); end
    endtask

    task automatic test_periodic(input int period, input int high, input int e_duty,
                                 input int e_edges, input int e_lvl, input int e_lc);
        int nlc = 0;
        for (int i = 0; i < 4 * W; i++) begin
            cyc((ph % period) < high, 1);
            ph++;
            if (lc2) nlc++;
            checks++; if (dv2 !== m_dv || (m_dv && duty2 !== 5'(m_duty))) begin errors++; $display("FAIL per_model p=%0d h=%0d got=%0b/%0d exp=%0b/%0d", period, high, dv2, duty2, m_dv, m_duty); end
        end
        checks++; if (duty2 !== 5'(e_duty) || edg2 !== 8'(e_edges)) begin errors++; $display("FAIL per_meas p=%0d h=%0d got=%0d/%0d exp=%0d/%0d", period, high, duty2, edg2, e_duty, e_edges); end
        checks++; if (lvl2 !== 3'(e_lvl) || nlc != e_lc) begin errors++; $display("FAIL per_level p=%0d h=%0d got=%0d/%0d exp=%0d/%0d", period, high, lvl2, nlc, e_lvl, e_lc); end
    endtask

    task automatic test_glitch_window();
        int n2 = 0, n1 = 0, guard = 0;
        for (int i = 0; i < 3 * W; i++) begin cyc((ph % 4) < 2, 1); ph++; end
        while (!dv2 && guard < 2 * W) begin cyc((ph % 4) < 2, 1); ph++; guard++; end
        checks++; if (!dv2) begin errors++; $display("FAIL glitch_align got=0 exp=1"); end
        for (int i = 0; i < W; i++) begin
            cyc(1, 1);
            if (lc2) n2++;
            if (lc1) n1++;
        end
        for (int i = 0; i < 3 * W; i++) begin
            cyc((ph % 4) < 2, 1); ph++;
            if (lc2) n2++;
            if (lc1) n1++;
        end
        checks++; if (lvl2 !== 3'd3 || n2 != 0) begin errors++; $display("FAIL glitch_s2 got=%0d/%0d exp=3/0", lvl2, n2); end
        checks++; if (lvl1 !== 3'd3 || n1 != 2) begin errors++; $display("FAIL glitch_s1 got=%0d/%0d exp=3/2", lvl1, n1); end
    endtask

    task automatic test_toggle_enable();
        logic [WB:0] hd;
        logic [7:0]  he;
        logic [2:0]  hl;
        int n = 0, guard = 0;
        bit p = 0;
        for (int i = 0; i < 3 * W; i++) begin p = ~p; cyc(p, 1); end
        checks++; if (edg2 !== 8'd8 || duty2 !== 5'd8) begin errors++; $display("FAIL tog_edges got=%0d/%0d exp=8/8", edg2, duty2); end
        while (!dv2 && guard < 2 * W) begin p = ~p; cyc(p, 1); guard++; end
        for (int i = 0; i < 7; i++) begin p = ~p; cyc(p, 1); end
        hd = duty2; he = edg2; hl = lvl2;
        for (int i = 0; i < 5; i++) begin
            p = ~p; cyc(p, 0);
            checks++; if (dv2 !== 1'b0 || lc2 !== 1'b0) begin errors++; $display("FAIL dis_pulse cyc=%0d got=%0b/%0b exp=0/0", i, dv2, lc2); end
        end
        checks++; if (duty2 !== hd || edg2 !== he || lvl2 !== hl) begin errors++; $display("FAIL dis_hold got=%0d/%0d/%0d exp=%0d/%0d/%0d", duty2, edg2, lvl2, hd, he, hl); end
        while (n < 40) begin
            p = ~p; cyc(p, 1); n++;
            if (dv2) break;
        end
        checks++; if (n != W) begin errors++; $display("FAIL reen_latency got=%0d exp=%0d", n, W); end
    endtask

    task automatic test_random();
        int thr = 8;
        bit en = 1;
        for (int i = 0; i < 600; i++) begin
            if (i % 32 == 0) thr = $urandom_range(0, 16);
            if ($urandom_range(0, 63) == 0) en = 0;
            else if (!en && $urandom_range(0, 3) == 0) en = 1;
            cyc($urandom_range(0, 15) < thr, en);
            checks++; if (dv2 !== m_dv || dv1 !== m_dv) begin errors++; $display("FAIL rnd_dv cyc=%0d got=%0b/%0b exp=%0b", i, dv2, dv1, m_dv); end
            checks++; if (duty2 !== 5'(m_duty) || edg2 !== 8'(m_edges) || duty1 !== 5'(m_duty)) begin errors++; $display("FAIL rnd_meas cyc=%0d got=%0d/%0d exp=%0d/%0d", i, duty2, edg2, m_duty, m_edges); end
            checks++; if (lvl2 !== 3'(m_lvl[0]) || lv2 !== m_lv[0] || lc2 !== m_lc[0]) begin errors++; $display("FAIL rnd_s2 cyc=%0d got=%0d/%0b/%0b exp=%0d/%0b/%0b", i, lvl2, lv2, lc2, m_lvl[0], m_lv[0], m_lc[0]); end
            checks++; if (lvl1 !== 3'(m_lvl[1]) || lv1 !== m_lv[1] || lc1 !== m_lc[1]) begin errors++; $display("FAIL rnd_s1 cyc=%0d got=%0d/%0b/%0b exp=%0d/%0b/%0b", i, lvl1, lv1, lc1, m_lvl[1], m_lv[1], m_lc[1]); end
        end
    endtask

    initial begin
        test_reset();
        test_const_high();
        test_async_reset();
        test_periodic(4, 2, 8, 4, 3, 1);
        test_periodic(16, 2, 2, 1, 1, 1);
        test_periodic(16, 1, 1, 1, 1, 0);
        test_periodic(16, 0, 0, 0, 0, 1);
        test_glitch_window();
        test_toggle_enable();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
